// File: rtl/timer_digits_pkg.sv
// Shared widths, constants and FSM state type for the M:SS digit converter.
package timer_pkg;
  localparam int TIME_W       = 10;
  localparam int SECS_PER_MIN = 60;
  localparam int BCD_W        = 4;
  localparam int DIGIT_SHIFTS = 6;
  localparam int BIN_W        = 6;
  localparam int QUO_W        = 5;
  localparam int SHIFT_W      = 3;
  localparam int BCD_PAIR_W   = 2 * BCD_W;

  typedef enum logic [1:0] {IDLE, DIV, BCD, OUT} t_digits_state;
endpackage

// File: rtl/timer_digits_if.sv
// Timer-side inputs and HUD-side digit/status outputs of timer_digits.
interface timer_digits_if;
  import timer_pkg::*;

  logic [TIME_W-1:0] time_in;
  logic              timer_done_in;
  logic [BCD_W-1:0]  min_tens_out;
  logic [BCD_W-1:0]  min_ones_out;
  logic [BCD_W-1:0]  sec_tens_out;
  logic [BCD_W-1:0]  sec_ones_out;
  logic              digits_valid_out;
  logic              busy_out;
  logic              low_time_out;
  logic              game_over_out;
  logic              flash_out;

  modport master (
    output time_in, timer_done_in,
    input  min_tens_out, min_ones_out, sec_tens_out, sec_ones_out,
    input  digits_valid_out, busy_out, low_time_out, game_over_out, flash_out
  );

  modport slave (
    input  time_in, timer_done_in,
    output min_tens_out, min_ones_out, sec_tens_out, sec_ones_out,
    output digits_valid_out, busy_out, low_time_out, game_over_out, flash_out
  );
endinterface

// File: rtl/timer_digits_bcd_shift_step.sv
// One double-dabble step: add 3 to BCD nibbles >= 5, then shift {bcd, bin} left by one.
module bcd_shift_step
  import timer_pkg::*;
(
  input  logic [BIN_W-1:0]      bin_in,
  input  logic [BCD_PAIR_W-1:0] bcd_in,
  output logic [BIN_W-1:0]      bin_out,
  output logic [BCD_PAIR_W-1:0] bcd_out
);
  logic [BCD_PAIR_W-1:0] adj;

  always_comb begin
    adj = bcd_in;
    if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
    if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
    {bcd_out, bin_out} = {adj[BCD_PAIR_W-2:0], bin_in, 1'b0};
  end
endmodule

// File: rtl/timer_digits.sv
// Seconds -> M:SS BCD converter (sequential divide by 60, then double-dabble).
// Optional blinking warning output enabled by defining TIMER_DIGITS_FLASH_EN.
//
// state | meaning
// IDLE  | waiting for a new time value (or the forced post-reset conversion)
// DIV   | repeated subtraction of 60, one step per cycle
// BCD   | six parallel double-dabble shifts for minutes and seconds
// OUT   | publish digits, low-time flag and valid pulse
module timer_digits
  import timer_pkg::*;
#(
  parameter int LOW_TIME_SECONDS = 10,
  parameter int FLASH_CYCLES     = 50000000
) (
  input  logic           clk_100mhz_in,
  input  logic           rst_in,
  timer_digits_if.slave  bus
);
  t_digits_state         state_q, state_d;
  logic [TIME_W-1:0]     rem_q, rem_d, last_q, last_d;
  logic [QUO_W-1:0]      quo_q, quo_d;
  logic                  pending_q, pending_d, busy_q, busy_d, valid_q, valid_d;
  logic                  low_q, low_d, go_q, go_d;
  logic [2*BCD_PAIR_W-1:0] digits_q, digits_d;
  logic [BIN_W-1:0]      min_bin_q, min_bin_d, sec_bin_q, sec_bin_d;
  logic [BCD_PAIR_W-1:0] min_bcd_q, min_bcd_d, sec_bcd_q, sec_bcd_d;
  logic [SHIFT_W-1:0]    shift_cnt_q, shift_cnt_d;
  logic [BIN_W-1:0]      min_bin_step, sec_bin_step;
  logic [BCD_PAIR_W-1:0] min_bcd_step, sec_bcd_step;

  if (FLASH_CYCLES < 1) begin : g_bad_flash_cycles
    $error("FLASH_CYCLES must be at least 1");
  end

  bcd_shift_step u_min_step (
    .bin_in (min_bin_q), .bcd_in (min_bcd_q),
    .bin_out(min_bin_step), .bcd_out(min_bcd_step)
  );

  bcd_shift_step u_sec_step (
    .bin_in (sec_bin_q), .bcd_in (sec_bcd_q),
    .bin_out(sec_bin_step), .bcd_out(sec_bcd_step)
  );

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    last_d      = last_q;
    pending_d   = pending_q;
    busy_d      = busy_q;
    valid_d     = 1'b0;
    low_d       = low_q;
    go_d        = go_q;
    digits_d    = digits_q;
    min_bin_d   = min_bin_q;
    sec_bin_d   = sec_bin_q;
    min_bcd_d   = min_bcd_q;
    sec_bcd_d   = sec_bcd_q;
    shift_cnt_d = shift_cnt_q;
    case (state_q)
      IDLE: begin
        if (pending_q || (bus.time_in != last_q)) begin
          rem_d     = bus.time_in;
          last_d    = bus.time_in;
          quo_d     = '0;
          busy_d    = 1'b1;
          pending_d = 1'b0;
          state_d   = DIV;
        end
      end
      DIV: begin
        if (rem_q >= TIME_W'(SECS_PER_MIN)) begin
          rem_d = rem_q - TIME_W'(SECS_PER_MIN);
          quo_d = quo_q + 1'b1;
        end else begin
          min_bin_d   = BIN_W'(quo_q);
          sec_bin_d   = rem_q[BIN_W-1:0];
          min_bcd_d   = '0;
          sec_bcd_d   = '0;
          shift_cnt_d = SHIFT_W'(DIGIT_SHIFTS - 1);
          state_d     = BCD;
        end
      end
      BCD: begin
        min_bin_d = min_bin_step;
        sec_bin_d = sec_bin_step;
        min_bcd_d = min_bcd_step;
        sec_bcd_d = sec_bcd_step;
        if (shift_cnt_q == '0) state_d = OUT;
        else                   shift_cnt_d = shift_cnt_q - 1'b1;
      end
      OUT: begin
        digits_d = {min_bcd_q, sec_bcd_q};
        valid_d  = 1'b1;
        low_d    = (last_q != '0) && (last_q <= TIME_W'(LOW_TIME_SECONDS));
        busy_d   = 1'b0;
        // A nonzero conversion means the timer was reloaded, so game-over ends.
        if (last_q != '0) go_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.timer_done_in) go_d = 1'b1;
  end

  always_ff @(posedge clk_100mhz_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      last_q      <= '0;
      pending_q   <= 1'b1;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      low_q       <= 1'b0;
      go_q        <= 1'b0;
      digits_q    <= '0;
      min_bin_q   <= '0;
      sec_bin_q   <= '0;
      min_bcd_q   <= '0;
      sec_bcd_q   <= '0;
      shift_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      last_q      <= last_d;
      pending_q   <= pending_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      low_q       <= low_d;
      go_q        <= go_d;
      digits_q    <= digits_d;
      min_bin_q   <= min_bin_d;
      sec_bin_q   <= sec_bin_d;
      min_bcd_q   <= min_bcd_d;
      sec_bcd_q   <= sec_bcd_d;
      shift_cnt_q <= shift_cnt_d;
    end
  end

`ifdef TIMER_DIGITS_FLASH_EN
  localparam int FLASH_W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
  logic               flash_q, flash_d;

  always_comb begin
    flash_cnt_d = '0;
    flash_d     = 1'b0;
    if (go_q) begin
      flash_d = 1'b1;
    end else if (low_q) begin
      flash_d = flash_q;
      if (flash_cnt_q == FLASH_W'(FLASH_CYCLES - 1)) flash_d = ~flash_q;
      else                                          flash_cnt_d = flash_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_100mhz_in) begin
    if (rst_in) begin
      flash_cnt_q <= '0;
      flash_q     <= 1'b0;
    end else begin
      flash_cnt_q <= flash_cnt_d;
      flash_q     <= flash_d;
    end
  end

  assign bus.flash_out = flash_q;
`else
  assign bus.flash_out = 1'b0;
`endif

  assign bus.min_tens_out     = digits_q[15:12];
  assign bus.min_ones_out     = digits_q[11:8];
  assign bus.sec_tens_out     = digits_q[7:4];
  assign bus.sec_ones_out     = digits_q[3:0];
  assign bus.digits_valid_out = valid_q;
  assign bus.busy_out         = busy_q;
  assign bus.low_time_out     = low_q;
  assign bus.game_over_out    = go_q;
endmodule

// File: tb/tb_timer_digits.sv
// Self-checking bench for timer_digits: directed scenarios plus random traffic against a transaction-level model.
module tb_timer_digits;
  import timer_pkg::*;

  localparam int LOW_T = 10;
  localparam int FC    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  timer_digits_if bus ();

  timer_digits #(.LOW_TIME_SECONDS(LOW_T), .FLASH_CYCLES(FC)) dut (
    .clk_100mhz_in(clk),
    .rst_in       (rst),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a conversion finishes floor(t/60)+8 edges after sampling.
  logic [15:0] m_digits = '0;
  bit m_valid = 0, m_busy = 0, m_low = 0, m_go = 0, m_flash = 0;
  bit m_pending = 1, m_active = 0, m_fin = 0;
  int m_last = 0, m_wait = 0, m_k = 0, m_t = 0;

  function automatic logic [15:0] mmss(int t);
    int m, s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  always @(posedge clk) begin
    m_t = int'(bus.time_in);
    if (rst) begin
      m_digits = '0; m_valid = 0; m_busy = 0; m_low = 0; m_go = 0; m_flash = 0;
      m_pending = 1; m_active = 0; m_last = 0; m_wait = 0; m_k = 0;
    end else begin
      if (m_go) begin
        m_flash = 1; m_k = 0;
      end else if (m_low) begin
        if (m_k == FC - 1) begin m_flash = !m_flash; m_k = 0; end
        else m_k++;
      end else begin
        m_flash = 0; m_k = 0;
      end
      m_valid = 0;
      m_fin   = 0;
      if (m_active) begin
        m_wait--;
        if (m_wait == 0) begin
          m_digits = mmss(m_last);
          m_valid  = 1;
          m_low    = (m_last != 0) && (m_last <= LOW_T);
          m_busy   = 0;
          m_active = 0;
          m_fin    = 1;
        end
      end else if (m_pending || m_t != m_last) begin
        m_last = m_t; m_pending = 0; m_busy = 1; m_active = 1;
        m_wait = m_t / 60 + 8;
      end
      if (bus.timer_done_in) m_go = 1;
      else if (m_fin && m_last != 0) m_go = 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("digits", int'({bus.min_tens_out, bus.min_ones_out, bus.sec_tens_out, bus.sec_ones_out}), int'(m_digits));
    chk("valid", int'(bus.digits_valid_out), int'(m_valid));
    chk("busy", int'(bus.busy_out), int'(m_busy));
    chk("low_time", int'(bus.low_time_out), int'(m_low));
    chk("game_over", int'(bus.game_over_out), int'(m_go));
`ifdef TIMER_DIGITS_FLASH_EN
    chk("flash", int'(bus.flash_out), int'(m_flash));
`else
    chk("flash", int'(bus.flash_out), 0);
`endif
  end

  task automatic drive(input int t, input bit d);
    @(negedge clk);
    #1;
    bus.time_in       = TIME_W'(t);
    bus.timer_done_in = d;
  endtask

  task automatic wait_valid(input int maxc, output int n, output int dig);
    bit found;
    found = 0;
    n     = 0;
    dig   = 0;
    while (!found && n < maxc) begin
      @(negedge clk);
      n++;
      if (bus.digits_valid_out) begin
        found = 1;
        dig = int'({bus.min_tens_out, bus.min_ones_out, bus.sec_tens_out, bus.sec_ones_out});
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL valid_timeout: got no pulse in %0d cycles, required a pulse", maxc);
    end
  endtask

  int n, dig, toggles;
  bit prev;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.time_in       = TIME_W'(60);
    bus.timer_done_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_digits", int'({bus.min_tens_out, bus.min_ones_out, bus.sec_tens_out, bus.sec_ones_out}), 0);
    chk("reset_busy", int'(bus.busy_out), 0);
    #1 rst = 1'b0;

    wait_valid(40, n, dig);
    chk("lat_60", n - 1, 9);
    chk("dig_60", dig, 'h0100);
    chk("low_60", int'(bus.low_time_out), 0);
    repeat (3) @(negedge clk);

    drive(59, 0);
    wait_valid(40, n, dig);
    chk("lat_59", n - 1, 8);
    chk("dig_59", dig, 'h0059);

    drive(1023, 0);
    wait_valid(40, n, dig);
    chk("lat_1023", n - 1, 25);
    chk("dig_1023", dig, 'h1703);

    drive(10, 0);
    wait_valid(40, n, dig);
    chk("dig_10", dig, 'h0010);
    chk("low_10", int'(bus.low_time_out), 1);

    drive(125, 0);
    repeat (2) @(negedge clk);
    #1 bus.time_in = TIME_W'(42);
    wait_valid(40, n, dig);
    chk("dig_125", dig, 'h0205);
    wait_valid(40, n, dig);
    chk("dig_42", dig, 'h0042);

    drive(5, 0);
    wait_valid(40, n, dig);
    chk("dig_5", dig, 'h0005);
    repeat (2) @(negedge clk);
`ifdef TIMER_DIGITS_FLASH_EN
    toggles = 0;
    prev = bus.flash_out;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.flash_out != prev) toggles++;
      prev = bus.flash_out;
    end
    chk("flash_toggles", toggles, 2);
`else
    chk("flash_off", int'(bus.flash_out), 0);
`endif

    drive(0, 1);
    @(negedge clk);
    chk("game_over_set", int'(bus.game_over_out), 1);
    #1 bus.timer_done_in = 1'b0;
    wait_valid(40, n, dig);
    chk("dig_0", dig, 'h0000);
    chk("low_0", int'(bus.low_time_out), 0);
    chk("go_hold_0", int'(bus.game_over_out), 1);
`ifdef TIMER_DIGITS_FLASH_EN
    chk("flash_go", int'(bus.flash_out), 1);
`endif
    drive(60, 0);
    wait_valid(40, n, dig);
    chk("go_clear", int'(bus.game_over_out), 0);
    chk("dig_reload", dig, 'h0100);

    drive(900, 0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    wait_valid(40, n, dig);
    chk("dig_900", dig, 'h1500);

    for (int it = 0; it < 300; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        @(negedge clk); #1 rst = 1'b1;
        @(negedge clk); #1 rst = 1'b0;
      end else if (r < 12) begin
        @(negedge clk); #1 bus.timer_done_in = 1'b1;
        @(negedge clk); #1 bus.timer_done_in = 1'b0;
      end else if (r < 55) begin
        if ($urandom_range(0, 1) == 0) drive($urandom_range(0, 20), 0);
        else                           drive($urandom_range(0, 1023), 0);
      end
      repeat ($urandom_range(1, 12)) @(negedge clk);
    end
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
